// File: rtl/collector_scheduler_if.sv
// -----------------------------------------------------------------------------
// collector_scheduler_if
//   Output stream of the collector scheduler: one result word per beat, tagged
//   with its source column, row index and an end-of-row marker.
//
//   Signals:
//     m_data  : result word (2*DATA_WIDTH+1 bits)
//     m_valid : beat valid, held until accepted
//     m_ready : downstream ready
//     m_col   : source column of m_data
//     m_row   : row index of m_data
//     m_last  : high on the beat from the last active column
//
//   Modports:
//     master : scheduler side (drives data/tags/valid, samples ready)
//     slave  : write-back side (samples data/tags/valid, drives ready)
// -----------------------------------------------------------------------------
interface collector_scheduler_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic [2*DATA_WIDTH:0] m_data;
    logic                  m_valid;
    logic                  m_ready;
    logic [7:0]            m_col;
    logic [15:0]           m_row;
    logic                  m_last;

    modport master (
        output m_data,
        output m_valid,
        output m_col,
        output m_row,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_valid,
        input  m_col,
        input  m_row,
        input  m_last,
        output m_ready
    );
endinterface

// File: rtl/collector_scheduler.sv
// -----------------------------------------------------------------------------
// collector_scheduler
//   Drains the PE column result FIFOs in strict column order (0..K-1) for R
//   rows and presents every popped word on a valid/ready stream tagged with
//   column, row and end-of-row. Only one pop is ever in flight, so a FIFO can
//   never underflow; an empty column stalls the sequence rather than being
//   skipped.
//
//   Ports:
//     i_clk          : system clock, rising edge
//     i_rstn         : synchronous active-low reset
//     i_start        : frame launch pulse, honoured only when idle
//     i_abort        : synchronous abort, highest priority, back to idle
//     i_kernel_size  : active column count K, sampled on start
//     i_num_rows     : row count R, sampled on start
//     i_col_empty    : per-column FIFO empty flags
//     o_col_rd_en    : one-hot FIFO pop
//     i_col_rd_data  : per-column FIFO read data, valid RD_LATENCY after pop
//     o_m            : output stream (master modport)
//     o_busy         : frame in progress
//     o_done         : one-cycle pulse at frame end
//     o_cfg_err      : one-cycle pulse when a start is rejected
// -----------------------------------------------------------------------------
module collector_scheduler #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_COL    = 7,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_start,
    input  logic                  i_abort,
    input  logic [7:0]            i_kernel_size,
    input  logic [15:0]           i_num_rows,
    input  logic [NUM_COL-1:0]    i_col_empty,
    output logic [NUM_COL-1:0]    o_col_rd_en,
    input  logic [2*DATA_WIDTH:0] i_col_rd_data [NUM_COL],
    collector_scheduler_if.master o_m,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_cfg_err
);

    localparam int unsigned ColW = (NUM_COL > 1) ? $clog2(NUM_COL) : 1;
    localparam int unsigned LatW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam logic [LatW-1:0] LatLast = LatW'(RD_LATENCY - 1);

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StWait,
        StOut,
        StDone
    } state_e;

    // Registered state
    state_e                r_state;
    logic [7:0]            r_k;
    logic [15:0]           r_r;
    logic [7:0]            r_col;
    logic [15:0]           r_row;
    logic [LatW-1:0]       r_wait_cnt;
    logic [2*DATA_WIDTH:0] r_m_data;
    logic [7:0]            r_m_col;
    logic [15:0]           r_m_row;
    logic                  r_m_last;
    logic                  r_m_valid;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_cfg_err;

    // Next-state values
    state_e                w_state_d;
    logic [7:0]            w_k_d;
    logic [15:0]           w_r_d;
    logic [7:0]            w_col_d;
    logic [15:0]           w_row_d;
    logic [LatW-1:0]       w_wait_cnt_d;
    logic [2*DATA_WIDTH:0] w_m_data_d;
    logic [7:0]            w_m_col_d;
    logic [15:0]           w_m_row_d;
    logic                  w_m_last_d;
    logic                  w_m_valid_d;
    logic                  w_busy_d;
    logic                  w_done_d;
    logic                  w_cfg_err_d;

    logic [NUM_COL-1:0]    w_col_rd_en;
    logic [ColW-1:0]       w_col_idx;
    logic                  w_cfg_bad;
    logic                  w_hs;
    logic                  w_col_last;
    logic                  w_row_last;

    // r_col never exceeds K-1 <= NUM_COL-1, so the low bits address the column.
    assign w_col_idx  = r_col[ColW-1:0];
    assign w_cfg_bad  = (i_kernel_size == 8'd0) || (i_kernel_size > 8'(NUM_COL)) ||
                        (i_num_rows == 16'd0);
    assign w_hs       = r_m_valid && o_m.m_ready;
    assign w_col_last = (r_col == r_k - 8'd1);
    assign w_row_last = (r_row == r_r - 16'd1);

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_state    <= StIdle;
            r_k        <= '0;
            r_r        <= '0;
            r_col      <= '0;
            r_row      <= '0;
            r_wait_cnt <= '0;
            r_m_data   <= '0;
            r_m_col    <= '0;
            r_m_row    <= '0;
            r_m_last   <= 1'b0;
            r_m_valid  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_cfg_err  <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_k        <= w_k_d;
            r_r        <= w_r_d;
            r_col      <= w_col_d;
            r_row      <= w_row_d;
            r_wait_cnt <= w_wait_cnt_d;
            r_m_data   <= w_m_data_d;
            r_m_col    <= w_m_col_d;
            r_m_row    <= w_m_row_d;
            r_m_last   <= w_m_last_d;
            r_m_valid  <= w_m_valid_d;
            r_busy     <= w_busy_d;
            r_done     <= w_done_d;
            r_cfg_err  <= w_cfg_err_d;
        end
    end

    always_comb begin
        w_state_d    = r_state;
        w_k_d        = r_k;
        w_r_d        = r_r;
        w_col_d      = r_col;
        w_row_d      = r_row;
        w_wait_cnt_d = r_wait_cnt;
        w_m_data_d   = r_m_data;
        w_m_col_d    = r_m_col;
        w_m_row_d    = r_m_row;
        w_m_last_d   = r_m_last;
        w_m_valid_d  = r_m_valid;
        w_busy_d     = r_busy;
        w_done_d     = 1'b0;
        w_cfg_err_d  = 1'b0;
        w_col_rd_en  = '0;

        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_k_d = i_kernel_size;
                    w_r_d = i_num_rows;
                    if (w_cfg_bad) begin
                        w_cfg_err_d = 1'b1;
                    end else begin
                        w_col_d   = '0;
                        w_row_d   = '0;
                        w_busy_d  = 1'b1;
                        w_state_d = StRead;
                    end
                end
            end

            StRead: begin
                // An empty column stalls here; columns are never skipped.
                if (!i_col_empty[w_col_idx]) begin
                    w_col_rd_en[w_col_idx] = 1'b1;
                    w_wait_cnt_d           = '0;
                    w_state_d              = StWait;
                end
            end

            StWait: begin
                if (r_wait_cnt == LatLast) begin
                    w_m_data_d  = i_col_rd_data[w_col_idx];
                    w_m_col_d   = r_col;
                    w_m_row_d   = r_row;
                    w_m_last_d  = w_col_last;
                    w_m_valid_d = 1'b1;
                    w_state_d   = StOut;
                end else begin
                    w_wait_cnt_d = r_wait_cnt + 1'b1;
                end
            end

            StOut: begin
                if (w_hs) begin
                    w_m_valid_d = 1'b0;
                    if (!w_col_last) begin
                        w_col_d   = r_col + 8'd1;
                        w_state_d = StRead;
                    end else if (!w_row_last) begin
                        w_col_d   = '0;
                        w_row_d   = r_row + 16'd1;
                        w_state_d = StRead;
                    end else begin
                        w_done_d  = 1'b1;
                        w_state_d = StDone;
                    end
                end
            end

            StDone: begin
                w_busy_d  = 1'b0;
                w_state_d = StIdle;
            end

            default: begin
                w_state_d = StIdle;
            end
        endcase

        // Abort overrides everything, including a handshake in the same cycle.
        // A word already popped is simply dropped.
        if (i_abort) begin
            w_state_d   = StIdle;
            w_col_d     = '0;
            w_row_d     = '0;
            w_m_valid_d = 1'b0;
            w_busy_d    = 1'b0;
            w_done_d    = 1'b0;
            w_cfg_err_d = 1'b0;
            w_col_rd_en = '0;
        end

        // No pop while reset is asserted; its word would be lost.
        if (!i_rstn) begin
            w_col_rd_en = '0;
        end
    end

    assign o_col_rd_en = w_col_rd_en;
    assign o_m.m_data  = r_m_data;
    assign o_m.m_valid = r_m_valid;
    assign o_m.m_col   = r_m_col;
    assign o_m.m_row   = r_m_row;
    assign o_m.m_last  = r_m_last;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_cfg_err   = r_cfg_err;

endmodule
